// File: rtl/proc_test_sequencer.sv
// Test sequencer: resets a core, waits for PC checkpoints,
// compares dmemout against expected values under a watchdog.
module proc_test_sequencer #(
  parameter int WIDTH = 64,
  parameter int NUM_CHECKS = 4,
  parameter int RESET_CYCLES = 1,
  parameter int SETTLE_CYCLES = 1,
  parameter int WDOG_WIDTH = 16,
  parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT = 16'h00FF
) (
  input  logic                          CLK,
  input  logic                          resetl,
  input  logic                          start,
  input  logic [WIDTH-1:0]              currentpc,
  input  logic [WIDTH-1:0]              dmemout,
  input  logic [NUM_CHECKS*WIDTH-1:0]   chk_pc,
  input  logic [NUM_CHECKS*WIDTH-1:0]   chk_val,
  output logic                          proc_resetl,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic                          all_pass,
  output logic [$clog2(NUM_CHECKS+1)-1:0] pass_count,
  output logic [NUM_CHECKS-1:0]         pass_mask,
  output logic                          fail_valid,
  output logic [3:0]                    fail_index,
  output logic [WIDTH-1:0]              fail_actual
);

  localparam int CW = $clog2(NUM_CHECKS+1);
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES-1);
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES-1);
  localparam logic [3:0] IDX_LAST = 4'(NUM_CHECKS-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_RUN,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic [3:0] idx;
  logic [15:0] cnt;
  logic [WDOG_WIDTH-1:0] wdog, wdog_inc;
  logic [WIDTH-1:0] cur_pc, cur_val;
  logic [NUM_CHECKS-1:0] sel;
  logic expire, match, last, launch;

  assign busy = state inside {S_PRST, S_RUN, S_SETTLE, S_CHECK};
  assign proc_resetl = state inside {S_RUN, S_SETTLE, S_CHECK};
  assign done = state == S_DONE;
  assign all_pass = done && !timeout
                 && pass_count == CW'(NUM_CHECKS);

  assign wdog_inc = wdog + 1'b1;
  assign expire = busy && wdog_inc == WDOG_LIMIT;
  assign launch = start && (state == S_IDLE || state == S_DONE);
  assign last = idx == IDX_LAST;
  assign cur_pc = WIDTH'(chk_pc >> (int'(idx) * WIDTH));
  assign cur_val = WIDTH'(chk_val >> (int'(idx) * WIDTH));
  assign match = dmemout == cur_val;
  assign sel = NUM_CHECKS'(1) << idx;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_PRST;
      S_PRST: if (cnt == RST_LAST) state_nxt = S_RUN;
      S_RUN: if (currentpc >= cur_pc) state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == SET_LAST) state_nxt = S_CHECK;
      S_CHECK: state_nxt = last ? S_DONE : S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    // watchdog wins over any scheduled compare
    if (expire) state_nxt = S_DONE;
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      wdog <= '0;
      timeout <= 1'b0;
      pass_count <= '0;
      pass_mask <= '0;
      fail_valid <= 1'b0;
      fail_index <= '0;
      fail_actual <= '0;
    end else begin
      state <= state_nxt;
      cnt <= (state_nxt == state) ? cnt + 16'd1 : '0;
      if (launch) begin
        idx <= '0;
        wdog <= '0;
        timeout <= 1'b0;
        pass_count <= '0;
        pass_mask <= '0;
        fail_valid <= 1'b0;
        fail_index <= '0;
        fail_actual <= '0;
      end else if (busy) begin
        wdog <= wdog_inc;
        if (expire) begin
          timeout <= 1'b1;
        end else if (state == S_CHECK) begin
          if (match) begin
            pass_mask <= pass_mask | sel;
            pass_count <= pass_count + 1'b1;
          end else if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_index <= idx;
            fail_actual <= dmemout;
          end
          if (!last) idx <= idx + 4'd1;
        end
      end
    end
  end

endmodule
